spring_scheduler: RTL and testbench

- Time-multiplexes one `spring` force unit across a table of up to N_SPRINGS springs, each joining two nodes of the soft-body mesh.
- On each physics step it walks the enabled springs in index order and fetches both endpoints' position and velocity from node memory.
- For each spring it issues one spring computation and accumulates the returned force: + onto node B, − onto node A.
- It then signals step_done so the integrator can read per-node net spring force.

---
 rtl/spring_pkg.sv | 45 ++++
 rtl/spring_scheduler_force_accumulator.sv | 50 +++++
 rtl/spring_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_spring_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spring_pkg.sv
// Shared types for the spring scheduler: FSM states, spring table entry and saturating add.
// Entry widths match the default mesh (8 nodes, 16-bit positions).
package spring_pkg;

    localparam int SPR_NODE_W = 3;
    localparam int SPR_EQ_W   = 16;

    typedef enum logic [3:0] {
        IDLE,
        CLEAR,
        SCAN,
        FETCH_A,
        LATCH_A,
        LATCH_B,
        ISSUE,
        WAIT,
        ACCUM,
        DONE
    } sched_state_t;

    typedef struct packed {
        logic                  en;
        logic [SPR_NODE_W-1:0] node_a;
        logic [SPR_NODE_W-1:0] node_b;
        logic [SPR_EQ_W-1:0]   eq;
    } spring_entry_t;

    // Symmetric clamp to +/-(2^(width-1)-1); the most negative code is never produced.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned        width);
        logic signed [63:0] lim;
        logic signed [63:0] sum;
        lim = (64'sd1 <<< (width - 1)) - 64'sd1;
        sum = a + b;
        if (sum > lim) begin
            return lim;
        end
        if (sum < -lim) begin
            return -lim;
        end
        return sum;
    endfunction

endpackage

// File: rtl/spring_scheduler_force_accumulator.sv
// Per-node signed X/Y force accumulators with one-cycle clear and saturating add/sub pair.
// Latency: update visible the cycle after add_en; read port is combinational.
// Backpressure: none, accepts one add per cycle.
module force_accumulator
    import spring_pkg::*;
#(
    parameter int N_NODES    = 8,
    parameter int FORCE_SIZE = 24,
    parameter int ACC_SIZE   = 32
) (
    input  logic                              clk_in,
    input  logic                              rst_in_n,
    input  logic                              clr,
    input  logic                              add_en,
    input  logic [$clog2(N_NODES)-1:0]        node_a,
    input  logic [$clog2(N_NODES)-1:0]        node_b,
    input  logic signed [FORCE_SIZE-1:0]      force_x,
    input  logic signed [FORCE_SIZE-1:0]      force_y,
    input  logic [$clog2(N_NODES)-1:0]        rd_addr,
    output logic signed [ACC_SIZE-1:0]        rd_x,
    output logic signed [ACC_SIZE-1:0]        rd_y
);

    logic signed [ACC_SIZE-1:0] acc_x [N_NODES];
    logic signed [ACC_SIZE-1:0] acc_y [N_NODES];

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            for (int i = 0; i < N_NODES; i++) begin
                acc_x[i] <= '0;
                acc_y[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < N_NODES; i++) begin
                acc_x[i] <= '0;
                acc_y[i] <= '0;
            end
        end else if (add_en && (node_a != node_b)) begin
            // A self-loop spring nets to zero, so it is skipped outright.
            acc_x[node_b] <= ACC_SIZE'(sat_add(64'(acc_x[node_b]), 64'(force_x), ACC_SIZE));
            acc_y[node_b] <= ACC_SIZE'(sat_add(64'(acc_y[node_b]), 64'(force_y), ACC_SIZE));
            acc_x[node_a] <= ACC_SIZE'(sat_add(64'(acc_x[node_a]), -(64'(force_x)), ACC_SIZE));
            acc_y[node_a] <= ACC_SIZE'(sat_add(64'(acc_y[node_a]), -(64'(force_y)), ACC_SIZE));
        end
    end

    assign rd_x = acc_x[rd_addr];
    assign rd_y = acc_y[rd_addr];

endmodule

// File: rtl/spring_scheduler.sv
// Walks the spring table each step, feeds one shared spring unit and accumulates node forces.
// Latency: 5 cycles + spring unit latency per enabled spring, 1 cycle per disabled one.
// Backpressure: step_start ignored while busy; a silent spring unit is abandoned after TIMEOUT.
module spring_scheduler
    import spring_pkg::*;
#(
    parameter int N_NODES       = 8,
    parameter int N_SPRINGS     = 16,
    parameter int POSITION_SIZE = 16,
    parameter int VELOCITY_SIZE = 16,
    parameter int CONSTANT_SIZE = 16,
    parameter int FORCE_SIZE    = 24,
    parameter int ACC_SIZE      = 32,
    parameter int TIMEOUT       = 1023
) (
    input  logic                              clk_in,
    input  logic                              rst_in_n,
    input  logic                              cfg_we,
    input  logic [$clog2(N_SPRINGS)-1:0]      cfg_idx,
    input  logic                              cfg_en,
    input  logic [$clog2(N_NODES)-1:0]        cfg_node_a,
    input  logic [$clog2(N_NODES)-1:0]        cfg_node_b,
    input  logic signed [POSITION_SIZE-1:0]   cfg_eq,
    input  logic signed [CONSTANT_SIZE-1:0]   k_in,
    input  logic signed [CONSTANT_SIZE-1:0]   b_in,
    input  logic                              step_start,
    output logic                              busy,
    output logic                              step_done,
    output logic                              timeout_err,
    output logic [$clog2(N_NODES)-1:0]        node_rd_addr,
    input  logic signed [POSITION_SIZE-1:0]   node_pos_x,
    input  logic signed [POSITION_SIZE-1:0]   node_pos_y,
    input  logic signed [VELOCITY_SIZE-1:0]   node_vel_x,
    input  logic signed [VELOCITY_SIZE-1:0]   node_vel_y,
    output logic                              spr_valid,
    output logic signed [POSITION_SIZE-1:0]   spr_v1 [1:0],
    output logic signed [POSITION_SIZE-1:0]   spr_v2 [1:0],
    output logic signed [POSITION_SIZE-1:0]   spr_eq,
    output logic signed [VELOCITY_SIZE-1:0]   spr_vel1_x,
    output logic signed [VELOCITY_SIZE-1:0]   spr_vel1_y,
    output logic signed [VELOCITY_SIZE-1:0]   spr_vel2_x,
    output logic signed [VELOCITY_SIZE-1:0]   spr_vel2_y,
    input  logic signed [FORCE_SIZE-1:0]      spr_force_x,
    input  logic signed [FORCE_SIZE-1:0]      spr_force_y,
    input  logic                              spr_result_valid,
    input  logic [$clog2(N_NODES)-1:0]        frc_rd_addr,
    output logic signed [ACC_SIZE-1:0]        frc_x,
    output logic signed [ACC_SIZE-1:0]        frc_y
);

    localparam int IDX_W  = $clog2(N_SPRINGS);
    localparam int NODE_W = $clog2(N_NODES);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    sched_state_t                  state, state_nxt;
    spring_entry_t                 spr_table [N_SPRINGS];
    spring_entry_t                 scan_entry;
    logic [IDX_W:0]                idx;
    logic [TMR_W-1:0]              tmr;
    logic [NODE_W-1:0]             cur_a, cur_b;
    logic [SPR_EQ_W-1:0]           cur_eq;
    logic signed [FORCE_SIZE-1:0]  frc_lat_x, frc_lat_y;
    logic                          idx_past, tmr_expired;
    logic                          acc_clr, acc_add;
    logic                          k_b_unused;

    // k and b are wired to the spring unit at mesh level; the scheduler never looks at them.
    assign k_b_unused  = ^{k_in, b_in};

    assign scan_entry  = spr_table[idx[IDX_W-1:0]];
    assign idx_past    = (idx == (IDX_W + 1)'(N_SPRINGS));
    assign tmr_expired = (tmr == TMR_W'(TIMEOUT));

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (step_start) state_nxt = CLEAR;
            CLEAR:   state_nxt = SCAN;
            SCAN: begin
                if (idx_past) begin
                    state_nxt = DONE;
                end else if (scan_entry.en) begin
                    state_nxt = FETCH_A;
                end
            end
            FETCH_A: state_nxt = LATCH_A;
            LATCH_A: state_nxt = LATCH_B;
            LATCH_B: state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (spr_result_valid) begin
                    state_nxt = ACCUM;
                end else if (tmr_expired) begin
                    state_nxt = SCAN;
                end
            end
            ACCUM:   state_nxt = SCAN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE) && (state != DONE);
        step_done = (state == DONE);
        spr_valid = (state == ISSUE);
        acc_clr   = (state == CLEAR);
        acc_add   = (state == ACCUM);
    end

    // Node memory answers one cycle after the address, so each address is set a state early.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            for (int i = 0; i < N_SPRINGS; i++) begin
                spr_table[i] <= '0;
            end
            idx          <= '0;
            tmr          <= '0;
            cur_a        <= '0;
            cur_b        <= '0;
            cur_eq       <= '0;
            node_rd_addr <= '0;
            spr_v1[0]    <= '0;
            spr_v1[1]    <= '0;
            spr_v2[0]    <= '0;
            spr_v2[1]    <= '0;
            spr_eq       <= '0;
            spr_vel1_x   <= '0;
            spr_vel1_y   <= '0;
            spr_vel2_x   <= '0;
            spr_vel2_y   <= '0;
            frc_lat_x    <= '0;
            frc_lat_y    <= '0;
            timeout_err  <= 1'b0;
        end else begin
            if (cfg_we) begin
                spr_table[cfg_idx] <= '{en:     cfg_en,
                                        node_a: SPR_NODE_W'(cfg_node_a),
                                        node_b: SPR_NODE_W'(cfg_node_b),
                                        eq:     SPR_EQ_W'(cfg_eq)};
            end
            case (state)
                CLEAR: idx <= '0;
                SCAN: begin
                    if (!idx_past) begin
                        if (!scan_entry.en) begin
                            idx <= idx + 1'b1;
                        end else begin
                            // Snapshot the entry so a concurrent table write cannot disturb it.
                            cur_a        <= NODE_W'(scan_entry.node_a);
                            cur_b        <= NODE_W'(scan_entry.node_b);
                            cur_eq       <= scan_entry.eq;
                            node_rd_addr <= NODE_W'(scan_entry.node_a);
                        end
                    end
                end
                FETCH_A: node_rd_addr <= cur_b;
                LATCH_A: begin
                    spr_v1[0]  <= node_pos_x;
                    spr_v1[1]  <= node_pos_y;
                    spr_vel1_x <= node_vel_x;
                    spr_vel1_y <= node_vel_y;
                end
                LATCH_B: begin
                    spr_v2[0]  <= node_pos_x;
                    spr_v2[1]  <= node_pos_y;
                    spr_vel2_x <= node_vel_x;
                    spr_vel2_y <= node_vel_y;
                    spr_eq     <= POSITION_SIZE'(cur_eq);
                end
                ISSUE: tmr <= '0;
                WAIT: begin
                    tmr <= tmr + 1'b1;
                    if (spr_result_valid) begin
                        frc_lat_x <= spr_force_x;
                        frc_lat_y <= spr_force_y;
                    end else if (tmr_expired) begin
                        timeout_err <= 1'b1;
                        idx         <= idx + 1'b1;
                    end
                end
                ACCUM: idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    force_accumulator #(
        .N_NODES    (N_NODES),
        .FORCE_SIZE (FORCE_SIZE),
        .ACC_SIZE   (ACC_SIZE)
    ) u_acc (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .clr      (acc_clr),
        .add_en   (acc_add),
        .node_a   (cur_a),
        .node_b   (cur_b),
        .force_x  (frc_lat_x),
        .force_y  (frc_lat_y),
        .rd_addr  (frc_rd_addr),
        .rd_x     (frc_x),
        .rd_y     (frc_y)
    );

endmodule

// File: tb/tb_spring_scheduler.sv
// Directed bench for spring_scheduler: node memory model, spring unit stub, and a narrow-accumulator twin.
module tb_spring_scheduler;

    localparam int N_SPRINGS = 16;
    localparam int TIMEOUT   = 1023;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic               rst_in_n, cfg_we, cfg_en, step_start, spr_result_valid;
    logic [3:0]         cfg_idx;
    logic [2:0]         cfg_node_a, cfg_node_b, frc_rd_addr;
    logic signed [15:0] cfg_eq, k_in, b_in;
    logic signed [15:0] node_pos_x, node_pos_y, node_vel_x, node_vel_y;
    logic signed [23:0] spr_force_x, spr_force_y;

    logic               busy, step_done, timeout_err, spr_valid;
    logic [2:0]         node_rd_addr;
    logic signed [15:0] spr_v1 [1:0];
    logic signed [15:0] spr_v2 [1:0];
    logic signed [15:0] spr_eq, spr_vel1_x, spr_vel1_y, spr_vel2_x, spr_vel2_y;
    logic signed [31:0] frc_x, frc_y;

    logic               busy_s, step_done_s, timeout_err_s, spr_valid_s;
    logic [2:0]         node_rd_addr_s;
    logic signed [15:0] spr_v1_s [1:0];
    logic signed [15:0] spr_v2_s [1:0];
    logic signed [15:0] spr_eq_s, spr_vel1_x_s, spr_vel1_y_s, spr_vel2_x_s, spr_vel2_y_s;
    logic signed [23:0] frc_x_s, frc_y_s;

    spring_scheduler dut (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_node_a(cfg_node_a), .cfg_node_b(cfg_node_b), .cfg_eq(cfg_eq), .k_in(k_in), .b_in(b_in),
        .step_start(step_start), .busy(busy), .step_done(step_done), .timeout_err(timeout_err),
        .node_rd_addr(node_rd_addr), .node_pos_x(node_pos_x), .node_pos_y(node_pos_y),
        .node_vel_x(node_vel_x), .node_vel_y(node_vel_y), .spr_valid(spr_valid),
        .spr_v1(spr_v1), .spr_v2(spr_v2), .spr_eq(spr_eq),
        .spr_vel1_x(spr_vel1_x), .spr_vel1_y(spr_vel1_y), .spr_vel2_x(spr_vel2_x), .spr_vel2_y(spr_vel2_y),
        .spr_force_x(spr_force_x), .spr_force_y(spr_force_y), .spr_result_valid(spr_result_valid),
        .frc_rd_addr(frc_rd_addr), .frc_x(frc_x), .frc_y(frc_y)
    );

    spring_scheduler #(.ACC_SIZE(24)) dut_sat (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_node_a(cfg_node_a), .cfg_node_b(cfg_node_b), .cfg_eq(cfg_eq), .k_in(k_in), .b_in(b_in),
        .step_start(step_start), .busy(busy_s), .step_done(step_done_s), .timeout_err(timeout_err_s),
        .node_rd_addr(node_rd_addr_s), .node_pos_x(node_pos_x), .node_pos_y(node_pos_y),
        .node_vel_x(node_vel_x), .node_vel_y(node_vel_y), .spr_valid(spr_valid_s),
        .spr_v1(spr_v1_s), .spr_v2(spr_v2_s), .spr_eq(spr_eq_s),
        .spr_vel1_x(spr_vel1_x_s), .spr_vel1_y(spr_vel1_y_s), .spr_vel2_x(spr_vel2_x_s), .spr_vel2_y(spr_vel2_y_s),
        .spr_force_x(spr_force_x), .spr_force_y(spr_force_y), .spr_result_valid(spr_result_valid),
        .frc_rd_addr(frc_rd_addr), .frc_x(frc_x_s), .frc_y(frc_y_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Synchronous-read node memory: data follows the address by one cycle.
    logic signed [15:0] mem_px [8];
    logic signed [15:0] mem_py [8];
    logic signed [15:0] mem_vx [8];
    logic signed [15:0] mem_vy [8];
    always @(posedge clk_in) begin
        node_pos_x <= mem_px[node_rd_addr];
        node_pos_y <= mem_py[node_rd_addr];
        node_vel_x <= mem_vx[node_rd_addr];
        node_vel_y <= mem_vy[node_rd_addr];
    end

    // Spring unit stub: answers stub_delay cycles after each spr_valid pulse.
    bit                 stub_en = 1'b1;
    int                 stub_delay = 2;
    logic signed [23:0] stub_fx = '0, stub_fy = '0;
    initial begin
        spr_result_valid = 1'b0;
        spr_force_x      = '0;
        spr_force_y      = '0;
        forever begin
            @(negedge clk_in);
            if (spr_valid && stub_en) begin
                repeat (stub_delay - 1) @(negedge clk_in);
                spr_result_valid = 1'b1;
                spr_force_x      = stub_fx;
                spr_force_y      = stub_fy;
                @(negedge clk_in);
                spr_result_valid = 1'b0;
            end
        end
    end

    // Operand monitor: counts issue pulses, snapshots operands and watches them while waiting.
    logic [143:0] ops_now, ops_snap;
    assign ops_now = {spr_v1[0], spr_v1[1], spr_v2[0], spr_v2[1], spr_eq,
                      spr_vel1_x, spr_vel1_y, spr_vel2_x, spr_vel2_y};
    int vld_pulses = 0;
    int unstable   = 0;
    bit in_wait    = 1'b0;
    bit snap_taken = 1'b0;
    initial begin
        ops_snap = '0;
        forever begin
            @(negedge clk_in);
            if (spr_valid) begin
                vld_pulses++;
                in_wait    = 1'b1;
                snap_taken = 1'b0;
            end else if (in_wait) begin
                if (!snap_taken) begin
                    ops_snap   = ops_now;
                    snap_taken = 1'b1;
                end else if (ops_now !== ops_snap) begin
                    unstable++;
                end
                if (spr_result_valid || !busy) in_wait = 1'b0;
            end
        end
    end

    task automatic wr(input int idx, input bit en, input int a, input int b, input int eq);
        @(negedge clk_in);
        cfg_we     = 1'b1;
        cfg_idx    = idx[3:0];
        cfg_en     = en;
        cfg_node_a = a[2:0];
        cfg_node_b = b[2:0];
        cfg_eq     = eq[15:0];
        @(negedge clk_in);
        cfg_we     = 1'b0;
    endtask

    task automatic run_step(input string tag, input int limit, output int lat);
        bit seen;
        @(negedge clk_in);
        step_start = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk_in);
            step_start = 1'b0;
            lat++;
            if (step_done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        @(negedge clk_in);
        check({tag, "_done_one_pulse"}, step_done, 0);
        check({tag, "_idle_after"}, busy, 0);
    endtask

    task automatic chk_frc(input string tag, input int node, input int ex, input int ey);
        frc_rd_addr = node[2:0];
        #1;
        check({tag, "_x"}, frc_x, ex);
        check({tag, "_y"}, frc_y, ey);
    endtask

    task automatic chk_frc_sat(input string tag, input int node, input int ex, input int ey);
        frc_rd_addr = node[2:0];
        #1;
        check({tag, "_x"}, frc_x_s, ex);
        check({tag, "_y"}, frc_y_s, ey);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lat;
    int p0;
    initial begin
        rst_in_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_node_a = '0; cfg_node_b = '0;
        cfg_eq = '0; k_in = 16'sd3; b_in = 16'sd1; step_start = 1'b0; frc_rd_addr = '0;
        for (int i = 0; i < 8; i++) begin
            mem_px[i] = 16'(i * 100); mem_py[i] = 16'(i * 7); mem_vx[i] = 16'(i); mem_vy[i] = 16'(-i);
        end
        mem_px[0] = 0;  mem_py[0] = 0; mem_vx[0] = 1; mem_vy[0] = 2;
        mem_px[1] = 10; mem_py[1] = 0; mem_vx[1] = 3; mem_vy[1] = 4;

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_step_done", step_done, 0);
        check("rst_spr_valid", spr_valid, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_node_rd_addr", node_rd_addr, 0);
        chk_frc("rst_frc0", 0, 0, 0);
        @(negedge clk_in);
        rst_in_n = 1'b1;

        // Single spring 0->1, force (-50,0) after 20 cycles
        wr(0, 1'b1, 0, 1, 5);
        stub_delay = 20; stub_fx = -24'sd50; stub_fy = 24'sd0;
        p0 = vld_pulses;
        unstable = 0;
        run_step("one", 500, lat);
        check("one_valid_pulses", vld_pulses - p0, 1);
        check("one_ops_stable", unstable, 0);
        check("one_v1x", $signed(ops_snap[143:128]), 0);
        check("one_v2x", $signed(ops_snap[111:96]), 10);
        check("one_eq", $signed(ops_snap[79:64]), 5);
        check("one_vel1x", $signed(ops_snap[63:48]), 1);
        check("one_vel2y", $signed(ops_snap[15:0]), 4);
        chk_frc("one_frc1", 1, -50, 0);
        chk_frc("one_frc0", 0, 50, 0);

        // Triangle 0->1, 1->2, 2->0, each (+7,-3): all nodes net zero
        wr(1, 1'b1, 1, 2, 0);
        wr(2, 1'b1, 2, 0, 0);
        stub_delay = 3; stub_fx = 24'sd7; stub_fy = -24'sd3;
        run_step("tri", 500, lat);
        chk_frc("tri_frc0", 0, 0, 0);
        chk_frc("tri_frc1", 1, 0, 0);
        chk_frc("tri_frc2", 2, 0, 0);

        // Drop the 0->1 spring: node1 is only endpoint A of 1->2
        wr(0, 1'b0, 0, 1, 0);
        run_step("tri_drop", 500, lat);
        chk_frc("tri_drop_frc0", 0, 7, -3);
        chk_frc("tri_drop_frc1", 1, -7, 3);
        chk_frc("tri_drop_frc2", 2, 0, 0);

        // All entries disabled
        wr(1, 1'b0, 1, 2, 0);
        wr(2, 1'b0, 2, 0, 0);
        run_step("empty", 200, lat);
        check("empty_latency", lat, N_SPRINGS + 3);
        for (int n = 0; n < 8; n++) chk_frc($sformatf("empty_frc%0d", n), n, 0, 0);

        // Saturation: 16 springs 0->3 with full-scale forces
        for (int i = 0; i < N_SPRINGS; i++) wr(i, 1'b1, 0, 3, 0);
        stub_delay = 2; stub_fx = 24'sd8388607; stub_fy = -24'sd8388608;
        run_step("sat", 2000, lat);
        chk_frc("sat32_frc3", 3, 134217712, -134217728);
        chk_frc("sat32_frc0", 0, -134217712, 134217728);
        chk_frc_sat("sat24_frc3", 3, 8388607, -8388607);
        chk_frc_sat("sat24_frc0", 0, -8388607, 8388607);

        // Spring unit never answers: spring skipped, step still completes
        for (int i = 0; i < N_SPRINGS; i++) wr(i, (i == 0), 0, 1, 5);
        stub_en = 1'b0;
        check("to_err_before", timeout_err, 0);
        run_step("to", 3000, lat);
        check("to_err_after", timeout_err, 1);
        check("to_latency_window", (lat >= TIMEOUT) && (lat <= TIMEOUT + 40), 1);
        chk_frc("to_frc0", 0, 0, 0);
        chk_frc("to_frc1", 1, 0, 0);

        // Reset while parked in WAIT
        @(negedge clk_in);
        step_start = 1'b1;
        @(negedge clk_in);
        step_start = 1'b0;
        repeat (20) @(negedge clk_in);
        check("rw_busy_before", busy, 1);
        check("rw_v2x_before", spr_v2[0], 10);
        rst_in_n = 1'b0;
        #1;
        check("rw_busy", busy, 0);
        check("rw_timeout_err", timeout_err, 0);
        check("rw_v2x", spr_v2[0], 0);
        check("rw_node_rd_addr", node_rd_addr, 0);
        chk_frc("rw_frc1", 1, 0, 0);
        @(negedge clk_in);
        rst_in_n = 1'b1;
        stub_en  = 1'b1;
        run_step("rw_empty", 200, lat);
        check("rw_table_cleared_latency", lat, N_SPRINGS + 3);
        wr(0, 1'b1, 0, 1, 5);
        stub_delay = 5; stub_fx = -24'sd50; stub_fy = 24'sd0;
        run_step("rw_again", 500, lat);
        chk_frc("rw_again_frc1", 1, -50, 0);
        chk_frc("rw_again_frc0", 0, 50, 0);
        check("rw_again_timeout_err", timeout_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
